// File: rtl/pf_vf_upstream_arb.sv
// Round-robin, packet-locked merge of NUM_PORT router-side AXI-S ports toward the host,
// stamping each beat with its source port's PF/VF. Define PFVF_UPSTREAM_ARB_PKT_CNT_EN for per-port packet counters.
module pf_vf_upstream_arb #(
    parameter int NUM_PORT = 4,
    parameter int DATA_W   = 512,
    parameter int PF_W     = 3,
    parameter int VF_W     = 11,
    localparam int SRC_W   = $clog2(NUM_PORT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_PORT-1:0]      in_tvalid,
    output logic [NUM_PORT-1:0]      in_tready,
    input  logic [NUM_PORT*DATA_W-1:0] in_tdata,
    input  logic [NUM_PORT-1:0]      in_tlast,
    input  logic [NUM_PORT*PF_W-1:0] cfg_port_pf,
    input  logic [NUM_PORT*VF_W-1:0] cfg_port_vf,
    input  logic [NUM_PORT-1:0]      cfg_port_vf_active,
    output logic                     out_tvalid,
    input  logic                     out_tready,
    output logic [DATA_W-1:0]        out_tdata,
    output logic                     out_tlast,
    output logic [PF_W-1:0]          out_pf,
    output logic [VF_W-1:0]          out_vf,
    output logic                     out_vf_active,
    output logic [SRC_W-1:0]         out_src_port
`ifdef PFVF_UPSTREAM_ARB_PKT_CNT_EN
    ,
    output logic [NUM_PORT*32-1:0]   pkt_cnt
`endif
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state;
    logic [SRC_W-1:0]   last_grant;
    logic [SRC_W-1:0]   cand_p0;
    logic [SRC_W-1:0]   grant_idx_p0;
    logic               grant_vld_p0;
    logic               out_ok_p0;
    logic               accept_p0;

    logic [DATA_W-1:0]  data_arr [NUM_PORT];
    logic [PF_W-1:0]    pf_arr   [NUM_PORT];
    logic [VF_W-1:0]    vf_arr   [NUM_PORT];

    for (genvar p = 0; p < NUM_PORT; p++) begin : g_slice
        assign data_arr[p] = in_tdata[p*DATA_W +: DATA_W];
        assign pf_arr[p]   = cfg_port_pf[p*PF_W +: PF_W];
        assign vf_arr[p]   = cfg_port_vf[p*VF_W +: VF_W];
    end

    // Stage p0: grant selection (locked port, or round-robin search after last_grant)
    always_comb begin
        cand_p0      = '0;
        grant_vld_p0 = 1'b0;
        grant_idx_p0 = last_grant;
        if (state == LOCKED) begin
            grant_vld_p0 = 1'b1;
        end else begin
            for (int i = 1; i <= NUM_PORT; i++) begin
                cand_p0 = SRC_W'((int'(last_grant) + i) % NUM_PORT);
                if (!grant_vld_p0 && in_tvalid[cand_p0]) begin
                    grant_vld_p0 = 1'b1;
                    grant_idx_p0 = cand_p0;
                end
            end
        end
    end

    assign out_ok_p0 = !out_tvalid || out_tready;
    assign accept_p0 = grant_vld_p0 && in_tvalid[grant_idx_p0] && out_ok_p0;

    // in_tready is gated by rst so it drops immediately, not at the next edge
    always_comb begin
        in_tready = '0;
        if (grant_vld_p0 && out_ok_p0 && !rst)
            in_tready[grant_idx_p0] = 1'b1;
    end

    // Stage p1: output register and packet lock state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= SRC_W'(NUM_PORT - 1);
            out_tvalid    <= 1'b0;
            out_tdata     <= '0;
            out_tlast     <= 1'b0;
            out_pf        <= '0;
            out_vf        <= '0;
            out_vf_active <= 1'b0;
            out_src_port  <= '0;
        end else if (accept_p0) begin
            out_tvalid    <= 1'b1;
            out_tdata     <= data_arr[grant_idx_p0];
            out_tlast     <= in_tlast[grant_idx_p0];
            out_pf        <= pf_arr[grant_idx_p0];
            out_vf        <= vf_arr[grant_idx_p0];
            out_vf_active <= cfg_port_vf_active[grant_idx_p0];
            out_src_port  <= grant_idx_p0;
            last_grant    <= grant_idx_p0;
            state         <= in_tlast[grant_idx_p0] ? IDLE : LOCKED;
        end else if (out_tready) begin
            out_tvalid    <= 1'b0;
        end
    end

`ifdef PFVF_UPSTREAM_ARB_PKT_CNT_EN
    logic [31:0] cnt_p1 [NUM_PORT];

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORT; i++) cnt_p1[i] <= '0;
        end else if (accept_p0 && in_tlast[grant_idx_p0]) begin
            cnt_p1[grant_idx_p0] <= sat_inc(cnt_p1[grant_idx_p0]);
        end
    end

    for (genvar p = 0; p < NUM_PORT; p++) begin : g_cnt
        assign pkt_cnt[p*32 +: 32] = cnt_p1[p];
    end
`endif

endmodule

// File: tb/tb_pf_vf_upstream_arb.sv
// Scoreboard bench for pf_vf_upstream_arb: expected beats are queued in grant order as packets are loaded.
module tb_pf_vf_upstream_arb;
    localparam int NP = 4;
    localparam int DW = 64;
    localparam int PW = 3;
    localparam int VW = 11;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst;
    logic [NP-1:0]    in_tvalid, in_tready, in_tlast, cfg_port_vf_active;
    logic [NP*DW-1:0] in_tdata;
    logic [NP*PW-1:0] cfg_port_pf;
    logic [NP*VW-1:0] cfg_port_vf;
    logic             out_tvalid, out_tready, out_tlast, out_vf_active;
    logic [DW-1:0]    out_tdata;
    logic [PW-1:0]    out_pf;
    logic [VW-1:0]    out_vf;
    logic [SW-1:0]    out_src_port;
`ifdef PFVF_UPSTREAM_ARB_PKT_CNT_EN
    logic [NP*32-1:0] pkt_cnt;
`endif

    pf_vf_upstream_arb #(.NUM_PORT(NP), .DATA_W(DW), .PF_W(PW), .VF_W(VW)) dut (
        .clk(clk), .rst(rst),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata), .in_tlast(in_tlast),
        .cfg_port_pf(cfg_port_pf), .cfg_port_vf(cfg_port_vf), .cfg_port_vf_active(cfg_port_vf_active),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata), .out_tlast(out_tlast),
        .out_pf(out_pf), .out_vf(out_vf), .out_vf_active(out_vf_active), .out_src_port(out_src_port)
`ifdef PFVF_UPSTREAM_ARB_PKT_CNT_EN
        , .pkt_cnt(pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int port; logic [DW-1:0] data; logic last; } beat_t;
    typedef struct {
        logic [DW-1:0] data; logic last; logic [PW-1:0] pf; logic [VW-1:0] vf; logic act; logic [SW-1:0] src;
    } exp_t;

    beat_t src_q [$];
    exp_t  exp_q [$];

    logic          tv [NP];
    logic          tl [NP];
    logic [DW-1:0] td [NP];
    logic          tr [NP];
    logic          fire [NP];
    logic [PW-1:0] cfg_pf  [NP];
    logic [VW-1:0] cfg_vf  [NP];
    logic          cfg_act [NP];
    int            pkt_exp [NP];

    for (genvar g = 0; g < NP; g++) begin : g_pack
        assign in_tvalid[g]              = tv[g];
        assign in_tlast[g]               = tl[g];
        assign in_tdata[g*DW +: DW]      = td[g];
        assign cfg_port_pf[g*PW +: PW]   = cfg_pf[g];
        assign cfg_port_vf[g*VW +: VW]   = cfg_vf[g];
        assign cfg_port_vf_active[g]     = cfg_act[g];
        assign tr[g]                     = in_tready[g];
    end

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [31:0]   rdy_pat;
    logic          nogap, started, held_vld;
    logic [DW-1:0] held;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input int port, input int nbeats, input logic [DW-1:0] base);
        beat_t b;
        exp_t  e;
        for (int i = 0; i < nbeats; i++) begin
            b.port = port; b.data = base + DW'(i); b.last = (i == nbeats - 1);
            src_q.push_back(b);
            e.data = b.data; e.last = b.last; e.pf = cfg_pf[port]; e.vf = cfg_vf[port];
            e.act = cfg_act[port]; e.src = SW'(port);
            exp_q.push_back(e);
        end
        pkt_exp[port]++;
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            if (fire[p]) begin
                for (int i = 0; i < src_q.size(); i++) begin
                    if (src_q[i].port == p) begin
                        src_q.delete(i);
                        break;
                    end
                end
            end
        end
        for (int p = 0; p < NP; p++) begin
            tv[p] = 1'b0; tl[p] = 1'b0; td[p] = '0;
            for (int i = 0; i < src_q.size(); i++) begin
                if (src_q[i].port == p) begin
                    tv[p] = 1'b1; tl[p] = src_q[i].last; td[p] = src_q[i].data;
                    break;
                end
            end
        end
        out_tready = rdy_pat[0];
        rdy_pat    = {1'b1, rdy_pat[31:1]};
        #1;
        if (nogap && started && exp_q.size() != 0)
            check_eq("no_bubble", out_tvalid, 1);
        if (out_tvalid && out_tready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("data", out_tdata, e.data);
                check_eq("last", out_tlast, e.last);
                check_eq("pf", out_pf, e.pf);
                check_eq("vf", out_vf, e.vf);
                check_eq("vf_active", out_vf_active, e.act);
                check_eq("src_port", out_src_port, e.src);
            end
            started  = 1'b1;
            held_vld = 1'b0;
        end else if (out_tvalid) begin
            check_eq("stall_in_tready", in_tready, 0);
            if (held_vld) check_eq("stall_hold_data", out_tdata, held);
            held     = out_tdata;
            held_vld = 1'b1;
        end
        for (int p = 0; p < NP; p++) fire[p] = tv[p] && tr[p];
    endtask

    task automatic run(input logic [31:0] pat, input logic gapless);
        int n = 0;
        rdy_pat = pat; nogap = gapless; started = 1'b0; held_vld = 1'b0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < 200) begin
            step();
            n++;
        end
        check_eq("drain", 64'(src_q.size() + exp_q.size()), 0);
        nogap = 1'b0;
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        out_tready = 1'b0;
        rdy_pat = '1; nogap = 1'b0; started = 1'b0; held_vld = 1'b0; held = '0;
        for (int p = 0; p < NP; p++) begin
            tv[p] = 1'b0; tl[p] = 1'b0; td[p] = '0; fire[p] = 1'b0; pkt_exp[p] = 0;
        end
        cfg_pf[0] = 3'd1; cfg_vf[0] = 11'd100;  cfg_act[0] = 1'b0;
        cfg_pf[1] = 3'd2; cfg_vf[1] = 11'd200;  cfg_act[1] = 1'b1;
        cfg_pf[2] = 3'd5; cfg_vf[2] = 11'd17;   cfg_act[2] = 1'b1;
        cfg_pf[3] = 3'd7; cfg_vf[3] = 11'd2047; cfg_act[3] = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_out_tvalid", out_tvalid, 0);
        check_eq("rst_in_tready", in_tready, 0);
        check_eq("rst_out_tdata", out_tdata, 0);
        check_eq("rst_out_src_port", out_src_port, 0);
        rst = 1'b0;

        // one single-beat packet per port: round robin 0,1,2,3 back to back
        send(0, 1, 64'h100); send(1, 1, 64'h200); send(2, 1, 64'h300); send(3, 1, 64'h400);
        run('1, 1'b1);
`ifdef PFVF_UPSTREAM_ARB_PKT_CNT_EN
        check_eq("pkt_cnt2", pkt_cnt[2*32 +: 32], 32'(pkt_exp[2]));
`endif

        // locked 4-beat packet on port 1 while port 2 waits, then port 2 with no bubble
        send(1, 4, 64'h1000); send(2, 2, 64'h2000);
        run('1, 1'b1);

        // three-cycle output stall in the middle of a port-0 packet
        send(0, 3, 64'h5000);
        run(32'hFFFF_FFE3, 1'b0);

        // reset in the middle of a 3-beat port-3 packet
        send(3, 3, 64'h3000);
        rdy_pat = '1;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out_tvalid", out_tvalid, 0);
        check_eq("arst_out_tlast", out_tlast, 0);
        check_eq("arst_out_tdata", out_tdata, 0);
        check_eq("arst_out_pf", out_pf, 0);
        check_eq("arst_out_vf", out_vf, 0);
        check_eq("arst_out_vf_active", out_vf_active, 0);
        check_eq("arst_out_src_port", out_src_port, 0);
        check_eq("arst_in_tready", in_tready, 0);
        src_q.delete();
        exp_q.delete();
        for (int p = 0; p < NP; p++) begin
            tv[p] = 1'b0; tl[p] = 1'b0; fire[p] = 1'b0; pkt_exp[p] = 0;
        end
        @(negedge clk);
        rst = 1'b0;
        send(0, 1, 64'h600); send(1, 1, 64'h700);
        run('1, 1'b1);

        // wrap-around grant order 2,3,0 under irregular backpressure
        send(2, 2, 64'h8000); send(3, 1, 64'h9000); send(0, 3, 64'hA000);
        run(32'hF5B7_6D5A, 1'b0);

`ifdef PFVF_UPSTREAM_ARB_PKT_CNT_EN
        check_eq("pkt_cnt0", pkt_cnt[0*32 +: 32], 32'(pkt_exp[0]));
        check_eq("pkt_cnt1", pkt_cnt[1*32 +: 32], 32'(pkt_exp[1]));
        check_eq("pkt_cnt2_end", pkt_cnt[2*32 +: 32], 32'(pkt_exp[2]));
        check_eq("pkt_cnt3", pkt_cnt[3*32 +: 32], 32'(pkt_exp[3]));
`endif
        check_eq("idle_out_tvalid", out_tvalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pf_vf_upstream_arb.md
PF_VF_UPSTREAM_ARB -- requirements
Module: pf_vf_upstream_arb

Interface
- REQ-001 SHALL have parameter NUM_PORT, default 4, meaning the number of router-side ports merged toward the host (2..16).
- REQ-002 SHALL have parameter DATA_W, default 512, meaning the AXI-S data width.
- REQ-003 SHALL have parameter PF_W, default 3, meaning the PF field width.
- REQ-004 SHALL have parameter VF_W, default 11, meaning the VF field width.
- REQ-005 SHALL have port clk, input, 1 bit: the single clock.
- REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
- REQ-007 SHALL have port in_tvalid, input, NUM_PORT bits: per-port beat valid.
- REQ-008 SHALL have port in_tready, output, NUM_PORT bits: per-port beat accept.
- REQ-009 SHALL have port in_tdata, input, NUM_PORT*DATA_W bits: per-port data; port p occupies slice p.
- REQ-010 SHALL have port in_tlast, input, NUM_PORT bits: per-port last beat of a packet.
- REQ-011 SHALL have port cfg_port_pf, input, NUM_PORT*PF_W bits: routing-table PF per port (quasi-static).
- REQ-012 SHALL have port cfg_port_vf, input, NUM_PORT*VF_W bits: routing-table VF per port.
- REQ-013 SHALL have port cfg_port_vf_active, input, NUM_PORT bits: routing-table VF-active per port.
- REQ-014 SHALL have port out_tvalid, output, 1 bit, toward the host.
- REQ-015 SHALL have port out_tready, input, 1 bit, from the host.
- REQ-016 SHALL have ports out_tdata (DATA_W) and out_tlast (1), outputs.
- REQ-017 SHALL have ports out_pf (PF_W), out_vf (VF_W) and out_vf_active (1), outputs: the source function's routing-table entry stamped on each beat.
- REQ-018 SHALL have port out_src_port, output, clog2(NUM_PORT) bits: the granted port index.

Function
- REQ-019 SHALL have two states: IDLE and LOCKED.
- REQ-020 In IDLE SHALL grant the first requesting port in round-robin order, searching from last_grant+1 and wrapping at NUM_PORT-1 to 0.
- REQ-021 SHALL accept a beat on port g when in_tvalid[g], g is granted, and (!out_tvalid || out_tready); every other in_tready bit SHALL be 0.
- REQ-022 SHALL go IDLE->LOCKED when an accepted beat has tlast=0, and update last_grant to g.
- REQ-023 SHALL remain in IDLE when the accepted beat has tlast=1 (single-beat packet), and update last_grant.
- REQ-024 In LOCKED SHALL hold the grant on g, ignoring other requests, until a tlast=1 beat from g is accepted, then return to IDLE.
- REQ-025 SHALL give a back-to-back packet on a different port a zero-bubble start, with arbitration in the IDLE cycle that follows the last beat.
- REQ-026 SHALL register each accepted beat to the output with 1-cycle latency, holding out_* stable while out_tvalid=1 and out_tready=0.
- REQ-027 SHALL drive out_pf, out_vf and out_vf_active from the cfg_port_* slice of g, sampled at beat acceptance.
- REQ-028 SHALL sustain one beat per cycle while out_tready=1.
- REQ-029 SHALL make a port that deasserts tvalid mid-packet in LOCKED stall the output without losing the grant.

Reset
- REQ-030 On rst SHALL force state=IDLE, last_grant=NUM_PORT-1, out_tvalid=0, out_tlast=0, out_tdata=0, out_pf=0, out_vf=0, out_vf_active=0, out_src_port=0, in_tready=0.
- REQ-031 SHALL discard a packet in flight when rst asserts mid-packet; after release the next grant SHALL start at port 0.

Configuration
- REQ-032 With PFVF_UPSTREAM_ARB_PKT_CNT_EN defined, SHALL add output pkt_cnt (NUM_PORT*32 bits), one saturating counter per port incremented on each accepted tlast beat and cleared by rst.
- REQ-033 Without PFVF_UPSTREAM_ARB_PKT_CNT_EN defined, SHALL omit the pkt_cnt port and its logic.

Verification
- REQ-034 Ports 0..3 each send a 1-beat packet, out_tready=1 -> output order 0,1,2,3 on consecutive cycles, each with its cfg PF/VF.
- REQ-035 Port 1 sends a 4-beat packet while port 2 requests -> four port-1 beats contiguous, then port 2 with no idle cycle.
- REQ-036 out_tready=0 for 3 cycles mid-packet -> out_tdata is unchanged, in_tready=0 and no beat is lost.
- REQ-037 rst pulses during beat 2 of a 3-beat packet from port 3 -> outputs reach reset values asynchronously; after release a port-0 request is granted first.
- REQ-038 cfg_port_pf[2]=5, vf[2]=17, vf_active[2]=1 and port 2 sends -> out_pf=5, out_vf=17, out_vf_active=1, out_src_port=2; with PKT_CNT_EN defined, pkt_cnt[2] increments by 1.
